// File: rtl/sensor_packet_framer.sv
// rtl/sensor_packet_framer.sv - priority-arbitrated sensor sample to byte-stream framer
// Frame: 7E, {id,6'b0}, LEN, timestamp (MSB first), data (MSB first), checksum, 7E.
module sensor_packet_framer #(
   parameter int           NUM_CH  = 4,
   parameter int           DATA_W  = 16,
   parameter int           TS_W    = 16,
   parameter int           TS_DIV  = 1,
   parameter logic [7:0]   CH_PRIO = {2'b11, 2'b10, 2'b00, 2'b01}
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic [15:0]              pkt_count
);

   localparam int DB = DATA_W / 8;
   localparam int TSB = TS_W / 8;
   localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(TS_DIV - 1);
   localparam logic [7:0] LEN_BYTE = 8'(4 + TSB + DB);
   localparam logic [1:0] TS_LAST = 2'(TSB - 1);
   localparam logic [1:0] DB_LAST = 2'(DB - 1);

   typedef enum logic [2:0] {IDLE, START, HDR, LEN, TS, DATA, CKS, END} state_t;

   state_t              state, state_nxt;
   logic [1:0]          id_r;
   logic [DATA_W-1:0]   data_r;
   logic [TS_W-1:0]     ts_r;
   logic [TS_W-1:0]     ts_cnt;
   logic [PW-1:0]       ps_cnt;
   logic [1:0]          byte_cnt;
   logic [7:0]          cks;

   logic                found;
   logic [1:0]          best_prio;
   logic [1:0]          grant_id;
   logic [DATA_W-1:0]   grant_data;
   logic                take;
   logic                out_acc;

   // Strict '>' keeps the lowest index on a priority tie.
   always_comb begin
      found = 1'b0;
      best_prio = 2'b00;
      grant_id = 2'b00;
      grant_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (in_valid[k] && (!found || CH_PRIO[2*k +: 2] > best_prio)) begin
            found = 1'b1;
            best_prio = CH_PRIO[2*k +: 2];
            grant_id = 2'(k);
            grant_data = in_data[k*DATA_W +: DATA_W];
         end
      end
   end

   assign in_ready  = (state == IDLE && found) ? (NUM_CH'(1) << grant_id) : '0;
   assign take      = |(in_valid & in_ready);
   assign out_valid = (state != IDLE);
   assign busy      = (state != IDLE);
   assign out_acc   = out_valid & out_ready;

   always_comb begin
      out_data = 8'h00;
      case (state)
         START:   out_data = 8'h7E;
         HDR:     out_data = {id_r, 6'b0};
         LEN:     out_data = LEN_BYTE;
         TS:      out_data = ts_r[TS_W-1 -: 8];
         DATA:    out_data = data_r[DATA_W-1 -: 8];
         CKS:     out_data = cks;
         END:     out_data = 8'h7E;
         default: out_data = 8'h00;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = START;
         START:   if (out_acc) state_nxt = HDR;
         HDR:     if (out_acc) state_nxt = LEN;
         LEN:     if (out_acc) state_nxt = TS;
         TS:      if (out_acc && byte_cnt == TS_LAST) state_nxt = DATA;
         DATA:    if (out_acc && byte_cnt == DB_LAST) state_nxt = CKS;
         CKS:     if (out_acc) state_nxt = END;
         END:     if (out_acc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_cnt <= '0;
         ts_cnt <= '0;
      end else if (ps_cnt == PS_LAST) begin
         ps_cnt <= '0;
         ts_cnt <= ts_cnt + TS_W'(1);
      end else begin
         ps_cnt <= ps_cnt + PW'(1);
      end
   end

   // ts_r and data_r shift left as bytes leave, so the top byte is always next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_r      <= 2'b00;
         data_r    <= '0;
         ts_r      <= '0;
         byte_cnt  <= 2'b00;
         cks       <= 8'h00;
         pkt_count <= 16'h0000;
      end else if (take) begin
         id_r     <= grant_id;
         data_r   <= grant_data;
         ts_r     <= ts_cnt;
         byte_cnt <= 2'b00;
         cks      <= 8'h00;
      end else if (out_acc) begin
         case (state)
            HDR, LEN: cks <= cks + out_data;
            TS: begin
               cks      <= cks + out_data;
               ts_r     <= ts_r << 8;
               byte_cnt <= (byte_cnt == TS_LAST) ? 2'b00 : byte_cnt + 2'd1;
            end
            DATA: begin
               cks      <= cks + out_data;
               data_r   <= data_r << 8;
               byte_cnt <= (byte_cnt == DB_LAST) ? 2'b00 : byte_cnt + 2'd1;
            end
            END:     pkt_count <= pkt_count + 16'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_packet_framer.sv
// tb/tb_sensor_packet_framer.sv - scoreboard bench for sensor_packet_framer
// Two instances: default parameters (a) and DATA_W=32, TS_W=8, TS_DIV=4 (b).
module tb_sensor_packet_framer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  in_valid = '0, in_ready;
   logic [63:0] in_data = '0;
   logic [7:0]  out_data;
   logic        out_valid, out_ready = 1'b1, busy;
   logic [15:0] pkt_count;

   logic [3:0]   in_valid_b = '0, in_ready_b;
   logic [127:0] in_data_b = '0;
   logic [7:0]   out_data_b;
   logic         out_valid_b, busy_b;
   logic [15:0]  pkt_count_b;

   sensor_packet_framer u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .pkt_count(pkt_count)
   );

   sensor_packet_framer #(.DATA_W(32), .TS_W(8), .TS_DIV(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_data(in_data_b),
      .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
      .out_ready(1'b1), .busy(busy_b), .pkt_count(pkt_count_b)
   );

   always #5 clk = ~clk;

   int vec = 0, errs = 0;
   int cyc = 0;
   logic [8:0] qa[$], qb[$];
   logic [7:0] a_log[$], b_ts_log[$];
   bit   m_idle = 1, m_idle_b = 1, log_en = 0, b_go = 0, b_done = 0;
   int   byte_idx = 0, byte_idx_b = 0, rmode = 0, stall_cnt = 0;
   logic [15:0] exp_pkt = 0, exp_pkt_b = 0;
   int   pr[4] = '{1, 0, 2, 3};

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int winner(input logic [3:0] v);
      for (int p = 3; p >= 0; p--)
         for (int k = 0; k < 4; k++)
            if (v[k] && pr[k] == p) return k;
      return -1;
   endfunction

   function automatic void push_frame(input bit to_b, input int tsb, input int db,
                                      input logic [1:0] id, input logic [31:0] ts,
                                      input logic [31:0] d);
      logic [7:0] b[$];
      logic [7:0] s;
      b.push_back(8'h7E);
      b.push_back({id, 6'b0});
      b.push_back(8'(4 + tsb + db));
      for (int i = 0; i < tsb; i++) b.push_back(8'(ts >> (8 * (tsb - 1 - i))));
      for (int i = 0; i < db; i++)  b.push_back(8'(d >> (8 * (db - 1 - i))));
      s = 8'h00;
      for (int i = 1; i < b.size(); i++) s = s + b[i];
      b.push_back(s);
      b.push_back(8'h7E);
      for (int i = 0; i < b.size(); i++) begin
         if (to_b) qb.push_back({i == b.size() - 1, b[i]});
         else      qa.push_back({i == b.size() - 1, b[i]});
      end
   endfunction

   // Monitor for instance a: arbitration, busy/valid, pkt_count and every byte.
   always @(negedge clk) begin
      if (rst_n) begin
         int w;
         logic [3:0] er;
         chk("pkt_count", pkt_count, exp_pkt);
         chk("busy", busy, !m_idle);
         chk("out_valid", out_valid, !m_idle);
         w = winner(in_valid);
         er = (m_idle && w >= 0) ? 4'(1 << w) : 4'b0;
         chk("in_ready", in_ready, er);
         if (er != 0) begin
            push_frame(0, 2, 2, 2'(w), 32'(cyc & 16'hFFFF), 32'(in_data[w*16 +: 16]));
            m_idle = 0;
         end
         if (out_valid) begin
            if (qa.size() == 0) chk("unexpected_byte", out_data, 32'hXX);
            else begin
               chk("out_data", out_data, qa[0][7:0]);
               if (out_ready) begin
                  if (log_en) a_log.push_back(out_data);
                  byte_idx++;
                  if (qa[0][8]) begin
                     m_idle = 1;
                     exp_pkt++;
                     byte_idx = 0;
                  end
                  void'(qa.pop_front());
               end
            end
         end
      end
   end

   // Monitor for instance b (only channel 1 is driven).
   always @(negedge clk) begin
      if (rst_n) begin
         chk("b_pkt_count", pkt_count_b, exp_pkt_b);
         chk("b_in_ready", in_ready_b, m_idle_b ? in_valid_b : 4'b0);
         if (m_idle_b && in_valid_b[1]) begin
            push_frame(1, 1, 4, 2'd1, 32'((cyc / 4) & 8'hFF), in_data_b[63:32]);
            m_idle_b = 0;
         end
         if (out_valid_b) begin
            if (qb.size() == 0) chk("b_unexpected_byte", out_data_b, 32'hXX);
            else begin
               chk("b_out_data", out_data_b, qb[0][7:0]);
               if (byte_idx_b == 3) b_ts_log.push_back(out_data_b);
               byte_idx_b++;
               if (qb[0][8]) begin
                  chk("b_frame_len", byte_idx_b, 10);
                  m_idle_b = 1;
                  exp_pkt_b++;
                  byte_idx_b = 0;
               end
               void'(qb.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rmode == 2 && byte_idx == 4 && out_valid && stall_cnt < 3) begin
            out_ready = 1'b0;
            stall_cnt++;
         end else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
         else out_ready = 1'b1;
      end
   end

   task automatic apply_a(input logic [3:0] mask, input logic [63:0] d);
      logic [3:0] pend, g;
      int t;
      pend = mask;
      t = 0;
      in_data = d;
      in_valid = mask;
      while (pend != 0 && t < 400) begin
         @(negedge clk);
         g = in_ready & in_valid;
         @(posedge clk); #1;
         pend &= ~g;
         in_valid &= ~g;
         t++;
      end
      if (pend != 0) begin
         chk("grant_timeout", pend, 0);
         in_valid = '0;
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((qa.size() != 0 || !m_idle) && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_a", qa.size(), 0);
   endtask

   task automatic send_b(input logic [31:0] d);
      int t = 0;
      in_data_b[63:32] = d;
      in_valid_b = 4'b0010;
      do begin
         @(negedge clk);
         t++;
      end while (in_ready_b[1] !== 1'b1 && t < 400);
      chk("b_grant", in_ready_b, 4'b0010);
      @(posedge clk); #1;
      in_valid_b = '0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int t;
      t = 0;
      while (!b_go && t < 5000) begin @(posedge clk); t++; end
      while (cyc < 40 && t < 5000) begin @(posedge clk); #1; t++; end
      send_b(32'hA1B2C3D4);
      while (cyc < 1021 && t < 5000) begin @(posedge clk); #1; t++; end
      send_b($urandom);
      while (!m_idle_b && t < 5000) begin @(posedge clk); #1; t++; end
      send_b($urandom);
      while (!m_idle_b && t < 5000) begin @(posedge clk); #1; t++; end
      b_done = 1;
   end

   initial begin
      logic [7:0] golden[9];
      int t;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_pkt_count", pkt_count, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Abandon a frame mid-DATA with reset.
      apply_a(4'b0001, 64'h0000_0000_0000_ABCD);
      t = 0;
      while (byte_idx != 5 && t < 100) begin @(posedge clk); #1; t++; end
      chk("reach_data_state", byte_idx, 5);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_pkt_count", pkt_count, 0);
      qa.delete();
      m_idle = 1;
      byte_idx = 0;
      exp_pkt = 0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      b_go = 1;

      // ch2, data 1234, timestamp 5.
      t = 0;
      while (cyc != 5 && t < 100) begin @(posedge clk); #1; t++; end
      log_en = 1;
      apply_a(4'b0100, 64'h0000_1234_0000_0000);
      wait_drain();
      log_en = 0;
      golden = '{8'h7E, 8'h80, 8'h08, 8'h00, 8'h05, 8'h12, 8'h34, 8'hD3, 8'h7E};
      chk("golden_len", a_log.size(), 9);
      for (int i = 0; i < 9 && i < a_log.size(); i++) chk("golden_byte", a_log[i], golden[i]);
      chk("golden_pkt", pkt_count, 1);

      // Simultaneous ch0, ch1, ch3.
      apply_a(4'b1011, {$urandom, $urandom});
      wait_drain();

      // Stall on second timestamp byte.
      rmode = 2;
      stall_cnt = 0;
      apply_a(4'b0010, {$urandom, $urandom});
      wait_drain();
      chk("stall_cycles", stall_cnt, 3);

      rmode = 1;
      for (int n = 0; n < 25; n++) begin
         apply_a(4'($urandom_range(1, 15)), {$urandom, $urandom});
         if ($urandom_range(0, 1) == 1) wait_drain();
      end
      wait_drain();
      rmode = 0;

      t = 0;
      while (!b_done && t < 5000) begin @(posedge clk); #1; t++; end
      chk("b_done", b_done, 1);
      chk("b_frames", b_ts_log.size(), 3);
      if (b_ts_log.size() == 3) begin
         chk("b_ts_wrap_ff", b_ts_log[1], 8'hFF);
         chk("b_ts_after_wrap_small", b_ts_log[2] < 8'h10, 1);
      end
      chk("b_pkt_final", pkt_count_b, 3);
      chk("drain_b", qb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
